// File: rtl/alu_ctrl_mseq_pkg.sv
// alu_ctrl_mseq shared types: ALU codes, aluop encodings, FSM states.
// ALU_CTRL_MSEQ_DIV_EN adds the DIV state.
package alu_ctrl_mseq_pkg;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0011;
    localparam logic [3:0] ALU_OR    = 4'b0100;
    localparam logic [3:0] ALU_XOR   = 4'b0101;
    localparam logic [3:0] ALU_SLT   = 4'b0110;
    localparam logic [3:0] ALU_SLL   = 4'b1000;
    localparam logic [3:0] ALU_SLTU  = 4'b1001;
    localparam logic [3:0] ALU_SRL   = 4'b1010;
    localparam logic [3:0] ALU_SRA   = 4'b1011;
    localparam logic [3:0] ALU_LUI   = 4'b1100;
    localparam logic [3:0] ALU_AUIPC = 4'b1101;
    localparam logic [3:0] ALU_MOP   = 4'b1111;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_R     = 3'b010;
    localparam logic [2:0] OP_I     = 3'b011;
    localparam logic [2:0] OP_LUI   = 3'b100;
    localparam logic [2:0] OP_AUIPC = 3'b101;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_M    = 7'b0000001;

`ifdef ALU_CTRL_MSEQ_DIV_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd3
    } state_t;
`endif

    // funct3 map shared by I-type and the base R-type row
    function automatic logic [3:0] f3_code(
        input logic [2:0] f3,
        input logic       alt
    );
        logic [3:0] c;
        c = ALU_ADD;
        case (f3)
            3'b000: c = ALU_ADD;
            3'b001: c = ALU_SLL;
            3'b010: c = ALU_SLT;
            3'b011: c = ALU_SLTU;
            3'b100: c = ALU_XOR;
            3'b101: c = alt ? ALU_SRA : ALU_SRL;
            3'b110: c = ALU_OR;
            default: c = ALU_AND;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_ctrl_mseq_dec.sv
// Combinational decode of aluop/funct3/funct7 into ALU code and M flags.
// Without ALU_CTRL_MSEQ_DIV_EN the divide group decodes as illegal.
module alu_ctrl_mseq_dec
    import alu_ctrl_mseq_pkg::*;
(
    input  logic [2:0] aluop,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] alu_control,
    output logic       is_m,
    output logic       is_div,
    output logic       illegal
);

    logic r_ok;
    logic m_ok;

    assign r_ok = (funct7 == F7_BASE) || (funct7 == F7_ALT);
    assign m_ok = (funct7 == F7_M);

    always_comb begin
        alu_control = ALU_ADD;
        is_m        = 1'b0;
        is_div      = 1'b0;
        illegal     = 1'b0;
        unique case (1'b1)
            (aluop == OP_ADD):   alu_control = ALU_ADD;
            (aluop == OP_SUB):   alu_control = ALU_SUB;
            (aluop == OP_LUI):   alu_control = ALU_LUI;
            (aluop == OP_AUIPC): alu_control = ALU_AUIPC;
            (aluop == OP_I): begin
                alu_control = f3_code(funct3, funct7[5]);
            end
            (aluop == OP_R && r_ok): begin
                if (!funct7[5])
                    alu_control = f3_code(funct3, 1'b0);
                else if (funct3 == 3'b000)
                    alu_control = ALU_SUB;
                else if (funct3 == 3'b101)
                    alu_control = ALU_SRA;
                else
                    illegal = 1'b1;
            end
            (aluop == OP_R && m_ok): begin
`ifdef ALU_CTRL_MSEQ_DIV_EN
                alu_control = ALU_MOP;
                is_m        = 1'b1;
                is_div      = funct3[2];
`else
                if (!funct3[2]) begin
                    alu_control = ALU_MOP;
                    is_m        = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
`endif
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_mseq.sv
// ALU control decode with multi-cycle M-extension sequencer.
// Define ALU_CTRL_MSEQ_DIV_EN to build the restoring divider.
module alu_ctrl_mseq
    import alu_ctrl_mseq_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int MCYC_PER_BIT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      aluop,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      alu_control,
    output logic            is_m,
    output logic [XLEN-1:0] m_result,
    output logic            illegal
);

    localparam int ITER = XLEN / MCYC_PER_BIT;
    localparam int CW   = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    state_t state, nxt;

    logic            accept, busy, last;
    logic [3:0]      dec_ctrl;
    logic            dec_m, dec_div, dec_ill;
    logic            sa, sb, neg_a, neg_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic [XLEN-1:0] hi, lo, bq;
    logic [XLEN-1:0] hi_n, lo_n, res;
    logic [XLEN:0]   sum;
    logic [2*XLEN-1:0] prod;
    logic            neg_q;
    logic [1:0]      f3q;
    logic [CW-1:0]   cnt;

`ifdef ALU_CTRL_MSEQ_DIV_EN
    logic            div_q, neg_r, div_skip;
    logic [XLEN:0]   sh;
    logic [XLEN-1:0] skip_res, quo, rem;
`endif

    alu_ctrl_mseq_dec u_dec (
        .aluop       (aluop),
        .funct3      (funct3),
        .funct7      (funct7),
        .alu_control (dec_ctrl),
        .is_m        (dec_m),
        .is_div      (dec_div),
        .illegal     (dec_ill)
    );

    // signedness of each operand by M funct3
    assign sa    = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
    assign sb    = funct3[2] ? ~funct3[0] : ~funct3[1];
    assign neg_a = sa & op_a[XLEN-1];
    assign neg_b = sb & op_b[XLEN-1];
    assign mag_a = neg_a ? -op_a : op_a;
    assign mag_b = neg_b ? -op_b : op_b;

    assign accept = in_valid & in_ready & ~flush;
    assign last   = (cnt == LAST);

`ifdef ALU_CTRL_MSEQ_DIV_EN
    assign busy = (state == S_MUL) || (state == S_DIV);

    // zero divisor and signed overflow bypass the iteration
    assign div_skip = (op_b == '0) ||
        (sa && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (&op_b));
    assign skip_res = (op_b == '0) ?
        (funct3[1] ? op_a : '1) :
        (funct3[1] ? '0 : op_a);
`else
    assign busy = (state == S_MUL);
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (dec_ill || !dec_m)
                        nxt = S_DONE;
                    else if (!dec_div)
                        nxt = S_MUL;
`ifdef ALU_CTRL_MSEQ_DIV_EN
                    else
                        nxt = div_skip ? S_DONE : S_DIV;
`else
                    else
                        nxt = S_DONE;
`endif
                end
            end
            S_MUL: if (last) nxt = S_DONE;
`ifdef ALU_CTRL_MSEQ_DIV_EN
            S_DIV: if (last) nxt = S_DONE;
`endif
            S_DONE: if (out_ready) nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
        if (flush)
            nxt = S_IDLE;
    end

    always_comb begin
        in_ready  = (state == S_IDLE) && !rst;
        out_valid = (state == S_DONE);
    end

    // MCYC_PER_BIT shift-add or restoring-divide steps per cycle
    always_comb begin
        hi_n = hi;
        lo_n = lo;
        sum  = '0;
`ifdef ALU_CTRL_MSEQ_DIV_EN
        sh   = '0;
`endif
        for (int i = 0; i < MCYC_PER_BIT; i++) begin
`ifdef ALU_CTRL_MSEQ_DIV_EN
            if (div_q) begin
                sh = {hi_n, lo_n[XLEN-1]};
                if (sh >= {1'b0, bq}) begin
                    hi_n = XLEN'(sh - {1'b0, bq});
                    lo_n = {lo_n[XLEN-2:0], 1'b1};
                end else begin
                    hi_n = sh[XLEN-1:0];
                    lo_n = {lo_n[XLEN-2:0], 1'b0};
                end
            end else
`endif
            begin
                sum  = {1'b0, hi_n} +
                       (lo_n[0] ? {1'b0, bq} : '0);
                hi_n = sum[XLEN:1];
                lo_n = {sum[0], lo_n[XLEN-1:1]};
            end
        end
    end

    always_comb begin
        prod = {hi_n, lo_n};
        if (neg_q)
            prod = -prod;
        res = (f3q == 2'b00) ? prod[XLEN-1:0]
                             : prod[2*XLEN-1:XLEN];
`ifdef ALU_CTRL_MSEQ_DIV_EN
        quo = neg_q ? -lo_n : lo_n;
        rem = neg_r ? -hi_n : hi_n;
        if (div_q)
            res = f3q[1] ? rem : quo;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_control <= '0;
            is_m        <= 1'b0;
            illegal     <= 1'b0;
            m_result    <= '0;
            hi          <= '0;
            lo          <= '0;
            bq          <= '0;
            neg_q       <= 1'b0;
            f3q         <= '0;
            cnt         <= '0;
`ifdef ALU_CTRL_MSEQ_DIV_EN
            div_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else if (flush) begin
            cnt <= '0;
        end else if (accept) begin
            alu_control <= dec_ctrl;
            is_m        <= dec_m;
            illegal     <= dec_ill;
            m_result    <= '0;
            hi          <= '0;
            lo          <= mag_a;
            bq          <= mag_b;
            neg_q       <= neg_a ^ neg_b;
            f3q         <= funct3[1:0];
            cnt         <= '0;
`ifdef ALU_CTRL_MSEQ_DIV_EN
            div_q       <= dec_div;
            neg_r       <= neg_a;
            if (dec_div && div_skip)
                m_result <= skip_res;
`endif
        end else if (busy) begin
            hi  <= hi_n;
            lo  <= lo_n;
            cnt <= cnt + CW'(1);
            if (last)
                m_result <= res;
        end
    end

endmodule

// File: tb/tb_alu_ctrl_mseq.sv
// Directed-vector bench for alu_ctrl_mseq (XLEN=32, one bit per cycle).
// Divide vectors are used only when ALU_CTRL_MSEQ_DIV_EN is defined.
module tb_alu_ctrl_mseq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  aluop;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_control;
    logic        is_m;
    logic [31:0] m_result;
    logic        illegal;

    always #5 clk = ~clk;

    alu_ctrl_mseq #(.XLEN(32), .MCYC_PER_BIT(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .aluop       (aluop),
        .funct3      (funct3),
        .funct7      (funct7),
        .op_a        (op_a),
        .op_b        (op_b),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_control (alu_control),
        .is_m        (is_m),
        .m_result    (m_result),
        .illegal     (illegal)
    );

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic        m;
        logic        ill;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h",
                     name, act, exp);
        end
    endtask

    task automatic send(input logic [2:0] op,
                        input logic [2:0] f3,
                        input logic [6:0] f7,
                        input logic [31:0] a,
                        input logic [31:0] b);
        @(negedge clk);
        chk("in_ready_pre", in_ready, 1);
        aluop    = op;
        funct3   = f3;
        funct7   = f7;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        op_a     = 32'hdead_beef;
        op_b     = 32'h0bad_f00d;
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic ack(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_drop"}, out_valid, 0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        string t;
        t = $sformatf("v%0d", idx);
        send(v.op, v.f3, v.f7, v.a, v.b);
        wait_out(lat);
        chk({t, "_valid"}, out_valid, 1);
        chk({t, "_lat"}, lat, v.lat);
        chk({t, "_ctrl"}, alu_control, v.ctrl);
        chk({t, "_is_m"}, is_m, v.m);
        chk({t, "_ill"}, illegal, v.ill);
        chk({t, "_res"}, m_result, v.res);
        ack(t);
    endtask

    task automatic quiet(input string tag, input int n);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk(tag, seen, 0);
    endtask

    initial begin
        int lat;
        vec_t v;

        vq.push_back('{3'b000, 3'b000, 7'h00, 32'd1, 32'd2,
                       4'b0000, 1'b0, 1'b0, 32'd0, 1});
        vq.push_back('{3'b001, 3'b000, 7'h00, 32'd1, 32'd2,
                       4'b0001, 1'b0, 1'b0, 32'd0, 1});
        vq.push_back('{3'b100, 3'b000, 7'h00, 32'd0, 32'd0,
                       4'b1100, 1'b0, 1'b0, 32'd0, 1});
        vq.push_back('{3'b101, 3'b000, 7'h00, 32'd0, 32'd0,
                       4'b1101, 1'b0, 1'b0, 32'd0, 1});
        vq.push_back('{3'b110, 3'b000, 7'h00, 32'd0, 32'd0,
                       4'b0000, 1'b0, 1'b1, 32'd0, 1});
        vq.push_back('{3'b011, 3'b101, 7'h20, 32'd0, 32'd0,
                       4'b1011, 1'b0, 1'b0, 32'd0, 1});
        vq.push_back('{3'b011, 3'b101, 7'h00, 32'd0, 32'd0,
                       4'b1010, 1'b0, 1'b0, 32'd0, 1});
        vq.push_back('{3'b011, 3'b011, 7'h00, 32'd0, 32'd0,
                       4'b1001, 1'b0, 1'b0, 32'd0, 1});
        vq.push_back('{3'b010, 3'b101, 7'h20, 32'd0, 32'd0,
                       4'b1011, 1'b0, 1'b0, 32'd0, 1});
        vq.push_back('{3'b010, 3'b111, 7'h00, 32'd0, 32'd0,
                       4'b0011, 1'b0, 1'b0, 32'd0, 1});
        vq.push_back('{3'b010, 3'b000, 7'h20, 32'd0, 32'd0,
                       4'b0001, 1'b0, 1'b0, 32'd0, 1});
        vq.push_back('{3'b010, 3'b110, 7'h20, 32'd0, 32'd0,
                       4'b0000, 1'b0, 1'b1, 32'd0, 1});
        vq.push_back('{3'b010, 3'b000, 7'h02, 32'd0, 32'd0,
                       4'b0000, 1'b0, 1'b1, 32'd0, 1});
        vq.push_back('{3'b010, 3'b011, 7'h01,
                       32'hffff_ffff, 32'hffff_ffff,
                       4'b1111, 1'b1, 1'b0, 32'hffff_fffe, 33});
        vq.push_back('{3'b010, 3'b000, 7'h01,
                       32'd7, 32'hffff_fffd,
                       4'b1111, 1'b1, 1'b0, 32'hffff_ffeb, 33});
        vq.push_back('{3'b010, 3'b001, 7'h01,
                       32'h8000_0000, 32'h8000_0000,
                       4'b1111, 1'b1, 1'b0, 32'h4000_0000, 33});
        vq.push_back('{3'b010, 3'b010, 7'h01,
                       32'hffff_ffff, 32'd2,
                       4'b1111, 1'b1, 1'b0, 32'hffff_ffff, 33});
        vq.push_back('{3'b010, 3'b011, 7'h01,
                       32'h1234_5678, 32'h10,
                       4'b1111, 1'b1, 1'b0, 32'd1, 33});
`ifdef ALU_CTRL_MSEQ_DIV_EN
        vq.push_back('{3'b010, 3'b100, 7'h01,
                       32'h8000_0000, 32'hffff_ffff,
                       4'b1111, 1'b1, 1'b0, 32'h8000_0000, 1});
        vq.push_back('{3'b010, 3'b110, 7'h01,
                       32'd7, 32'd0,
                       4'b1111, 1'b1, 1'b0, 32'd7, 1});
        vq.push_back('{3'b010, 3'b101, 7'h01,
                       32'd5, 32'd0,
                       4'b1111, 1'b1, 1'b0, 32'hffff_ffff, 1});
        vq.push_back('{3'b010, 3'b110, 7'h01,
                       32'h8000_0000, 32'hffff_ffff,
                       4'b1111, 1'b1, 1'b0, 32'd0, 1});
        vq.push_back('{3'b010, 3'b100, 7'h01,
                       32'hffff_fff9, 32'd2,
                       4'b1111, 1'b1, 1'b0, 32'hffff_fffd, 33});
        vq.push_back('{3'b010, 3'b110, 7'h01,
                       32'hffff_fff9, 32'd2,
                       4'b1111, 1'b1, 1'b0, 32'hffff_ffff, 33});
        vq.push_back('{3'b010, 3'b111, 7'h01,
                       32'd100, 32'd7,
                       4'b1111, 1'b1, 1'b0, 32'd2, 33});
`else
        vq.push_back('{3'b010, 3'b111, 7'h01,
                       32'd100, 32'd7,
                       4'b0000, 1'b0, 1'b1, 32'd0, 1});
        vq.push_back('{3'b010, 3'b100, 7'h01,
                       32'd100, 32'd7,
                       4'b0000, 1'b0, 1'b1, 32'd0, 1});
`endif

        rst       = 1'b1;
        in_valid  = 1'b0;
        aluop     = '0;
        funct3    = '0;
        funct7    = '0;
        op_a      = '0;
        op_b      = '0;
        flush     = 1'b0;
        out_ready = 1'b0;

        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_ctrl", alu_control, 0);
        chk("post_rst_is_m", is_m, 0);
        chk("post_rst_ill", illegal, 0);
        chk("post_rst_res", m_result, 0);

        for (int i = 0; i < vq.size(); i++)
            run_vec(vq[i], i);

        // consumer stalls: result must hold and no new accept
`ifdef ALU_CTRL_MSEQ_DIV_EN
        send(3'b010, 3'b101, 7'h01, 32'd100, 32'd7);
        v.res = 32'd14;
`else
        send(3'b010, 3'b000, 7'h01, 32'd6, 32'd7);
        v.res = 32'd42;
`endif
        wait_out(lat);
        chk("hold_lat", lat, 33);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_res", m_result, v.res);
            chk("hold_in_ready", in_ready, 0);
            @(negedge clk);
        end
        chk("hold_res_end", m_result, v.res);
        ack("hold");
        chk("hold_idle_ready", in_ready, 1);

        // flush during cycle 10 of a multiply
        send(3'b010, 3'b000, 7'h01, 32'd3, 32'd5);
        for (int i = 0; i < 9; i++) @(negedge clk);
        chk("fl_busy_ready", in_ready, 0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fl_in_ready", in_ready, 1);
        chk("fl_out_valid", out_valid, 0);
        quiet("fl_no_resp", 40);
        run_vec(vq[0], 100);

        // flush while a response waits drops it
        send(3'b001, 3'b000, 7'h00, 32'd0, 32'd0);
        chk("fd_valid", out_valid, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fd_drop", out_valid, 0);
        chk("fd_ready", in_ready, 1);

        // reset mid-multiply, together with flush
        send(3'b010, 3'b011, 7'h01, 32'd9, 32'd9);
        for (int i = 0; i < 5; i++) @(negedge clk);
        rst   = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        chk("rm_in_ready", in_ready, 0);
        rst   = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        chk("rm_ctrl", alu_control, 0);
        chk("rm_is_m", is_m, 0);
        chk("rm_res", m_result, 0);
        chk("rm_ready", in_ready, 1);
        quiet("rm_no_resp", 40);
        run_vec(vq[8], 101);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
